// File: rtl/instr_encoder.sv
// instr_encoder
//   Packs R-/I-type instruction fields into 32-bit words and buffers them in a
//   DEPTH-entry FIFO. A write port then streams the words into instruction
//   memory at consecutive addresses.
//   The IDLE -> RUN -> DRAIN sequence is driven by start and stop pulses.
// Ports
//   clk, rst_n                  clock, async active-low reset
//   start, stop, base_addr      session control and first write address
//   in_valid/in_ready           field-set handshake (ri, rs, rd, rt, mode, f_code, imm)
//   imem_we/imem_ready          memory write handshake (imem_addr, imem_wdata)
//   busy, done, wcount, wrap_err  status
module instr_encoder #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  input  logic [AW-1:0] base_addr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          ri,
  input  logic [5:0]    rs,
  input  logic [5:0]    rd,
  input  logic [5:0]    rt,
  input  logic          mode,
  input  logic [2:0]    f_code,
  input  logic [14:0]   imm,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  input  logic          imem_ready,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   wcount,
  output logic          wrap_err
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          full, empty, push, pop, start_ok;
  logic [31:0]   packed_word;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign in_ready = (state == RUN) && !full;
  assign push     = in_valid && in_ready;
  assign imem_we  = !empty && (state != IDLE);
  assign pop      = imem_we && imem_ready;
  assign busy     = (state != IDLE);
  assign start_ok = (state == IDLE) && start;

  // Empty FIFO presents zero so the data bus reads 0 straight out of reset
  // without needing to clear the storage array.
  assign imem_wdata = empty ? '0 : mem[rd_ptr];

  always_comb begin
    packed_word        = '0;
    packed_word[31]    = ri;
    packed_word[30:25] = rs;
    packed_word[24:19] = rd;
    packed_word[18]    = mode;
    packed_word[17:15] = f_code;
    if (ri) packed_word[14:0] = imm;
    else    packed_word[14:9] = rt;
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = RUN;
      RUN:   if (stop)  state_nxt = DRAIN;
      DRAIN: if (empty) begin
        state_nxt = IDLE;
        done      = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      imem_addr <= '0;
      wcount    <= '0;
      wrap_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
      // pop cannot occur in IDLE, so start and write bookkeeping never collide
      if (start_ok) begin
        imem_addr <= base_addr;
        wcount    <= '0;
        wrap_err  <= 1'b0;
      end else if (pop) begin
        imem_addr <= imem_addr + AW'(1);
        if (imem_addr == '1) wrap_err <= 1'b1;
        if (wcount != '1)    wcount   <= wcount + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= packed_word;
  end

endmodule
